jump_redirect_ctrl: RTL and testbench

Sequences control-flow redirection for J, JAL, JR and JALR resolved in EX. Builds the 32-bit jump target from the 26-bit instruction index shifted left by two, or takes the register value for JR/JALR. Holds the redirect toward fetch under a valid/ready handshake, squashes wrong-path IF/ID contents and stalls EX until the redirect is consumed. Issues the link-register write for JAL/JALR. Sits between the EX stage, the PC/fetch unit and the register-file write port.

---
 rtl/jump_ctrl_pkg.sv | 20 ++
 rtl/jump_target_calc.sv | 23 ++
 rtl/jump_redirect_ctrl.sv | 120 ++++++++++++
 tb/tb_jump_redirect_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jump_ctrl_pkg.sv
// Shared types and constants for the EX-stage jump redirect controller.
package jump_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2,
    ERROR    = 2'd3
  } jumpState_e;

  localparam logic [4:0] LINK_REG    = 5'd31;
  localparam int         FLUSH_CNT_W = 4;

  // J/JAL target: PC+4 region bits pass through, no carry into [31:28].
  function automatic logic [31:0] jTarget(input logic [31:0] pcPlus4,
                                          input logic [25:0] instrIndex);
    return {pcPlus4[31:28], instrIndex, 2'b00};
  endfunction

endpackage

// File: rtl/jump_target_calc.sv
// Combinational jump target selection; JR/JALR register value wins over J/JAL.
module jump_target_calc
  import jump_ctrl_pkg::*;
(
  input  logic [25:0] instrIndex,
  input  logic [31:0] pcPlus4,
  input  logic [31:0] rsValue,
  input  logic        isJr,
  output logic [31:0] target,
  output logic        misaligned
);

  // Select the target source and flag register targets that are not word aligned.
  always_comb begin
    target     = jTarget(pcPlus4, instrIndex);
    misaligned = 1'b0;
    if (isJr) begin
      target     = rsValue;
      misaligned = (rsValue[1:0] != 2'b00);
    end
  end

endmodule

// File: rtl/jump_redirect_ctrl.sv
// Jump redirect controller: captures J/JAL/JR/JALR in EX, presents the new PC
// to fetch under valid/ready, squashes IF/ID and issues the link write.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for a jump in EX; ex_accept high
// REDIRECT | target presented to fetch, EX stalled, IF/ID squashed
// FLUSH    | redirect consumed; IF/ID squashed for the remaining count
// ERROR    | misaligned register target; one-cycle error pulse
module jump_redirect_ctrl
  import jump_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ex_valid,
  input  logic        ex_jump,
  input  logic        ex_jr,
  input  logic        ex_link,
  input  logic [25:0] ex_instr_index,
  input  logic [31:0] ex_pc_plus4,
  input  logic [31:0] ex_rs_value,
  output logic        ex_accept,
  output logic        stall_ex,
  output logic        flush,
  output logic        redir_valid,
  output logic [31:0] redir_target,
  input  logic        redir_ready,
  output logic        link_we,
  output logic [4:0]  link_reg,
  output logic [31:0] link_data,
  output logic        misalign_err
);

  jumpState_e             state;
  logic [FLUSH_CNT_W-1:0] flushCnt;
  logic [31:0]            calcTarget;
  logic                   calcMisaligned;
  logic                   capture;

  jump_target_calc uTargetCalc (
    .instrIndex (ex_instr_index),
    .pcPlus4    (ex_pc_plus4),
    .rsValue    (ex_rs_value),
    .isJr       (ex_jr),
    .target     (calcTarget),
    .misaligned (calcMisaligned)
  );

  assign ex_accept = (state == IDLE);
  assign capture   = ex_accept && ex_valid && (ex_jump || ex_jr);
  assign link_reg  = LINK_REG;

  // Sequencer with registered outputs; link write and error are single-cycle strobes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      flushCnt     <= '0;
      redir_valid  <= 1'b0;
      redir_target <= '0;
      flush        <= 1'b0;
      stall_ex     <= 1'b0;
      link_we      <= 1'b0;
      link_data    <= '0;
      misalign_err <= 1'b0;
    end else begin
      link_we      <= 1'b0;
      misalign_err <= 1'b0;
      case (state)
        IDLE: begin
          if (capture) begin
            redir_target <= calcTarget;
            if (calcMisaligned) begin
              state        <= ERROR;
              misalign_err <= 1'b1;
            end else begin
              state       <= REDIRECT;
              redir_valid <= 1'b1;
              flush       <= 1'b1;
              stall_ex    <= 1'b1;
              if (ex_link) begin
                link_we   <= 1'b1;
                link_data <= ex_pc_plus4;
              end
            end
          end
        end
        REDIRECT: begin
          if (redir_valid && redir_ready) begin
            redir_valid <= 1'b0;
            stall_ex    <= 1'b0;
            if (FLUSH_CYCLES == 0) begin
              state <= IDLE;
              flush <= 1'b0;
            end else begin
              state    <= FLUSH;
              flushCnt <= FLUSH_CNT_W'(FLUSH_CYCLES - 1);
            end
          end
        end
        FLUSH: begin
          if (flushCnt == '0) begin
            state <= IDLE;
            flush <= 1'b0;
          end else begin
            flushCnt <= flushCnt - FLUSH_CNT_W'(1);
          end
        end
        ERROR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jump_redirect_ctrl.sv
// Directed bench for jump_redirect_ctrl with a target/link scoreboard.
module tb_jump_redirect_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ex_valid, ex_jump, ex_jr, ex_link;
  logic [25:0] ex_instr_index;
  logic [31:0] ex_pc_plus4, ex_rs_value;
  logic        ex_accept, stall_ex, flush, redir_valid, redir_ready;
  logic [31:0] redir_target, link_data;
  logic        link_we, misalign_err;
  logic [4:0]  link_reg;

  int nCompared = 0;
  int nMismatch = 0;
  logic [31:0] expTarget[$];
  logic [31:0] expLink[$];
  logic [31:0] heldTarget;

  jump_redirect_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ex_valid       (ex_valid),
    .ex_jump        (ex_jump),
    .ex_jr          (ex_jr),
    .ex_link        (ex_link),
    .ex_instr_index (ex_instr_index),
    .ex_pc_plus4    (ex_pc_plus4),
    .ex_rs_value    (ex_rs_value),
    .ex_accept      (ex_accept),
    .stall_ex       (stall_ex),
    .flush          (flush),
    .redir_valid    (redir_valid),
    .redir_target   (redir_target),
    .redir_ready    (redir_ready),
    .link_we        (link_we),
    .link_reg       (link_reg),
    .link_data      (link_data),
    .misalign_err   (misalign_err)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chkWord(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp)
    else begin
      nMismatch++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkBit(input string tag, input logic obs, input logic exp);
    nCompared++;
    assert (obs === exp)
    else begin
      nMismatch++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] popTarget();
    if (expTarget.size() == 0) return 32'hxxxxxxxx;
    return expTarget.pop_front();
  endfunction

  function automatic logic [31:0] popLink();
    if (expLink.size() == 0) return 32'hxxxxxxxx;
    return expLink.pop_front();
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idleInputs();
    ex_valid       = 1'b0;
    ex_jump        = 1'b0;
    ex_jr          = 1'b0;
    ex_link        = 1'b0;
    ex_instr_index = '0;
    ex_pc_plus4    = '0;
    ex_rs_value    = '0;
  endtask

  task automatic present(input logic j, input logic jr, input logic lnk,
                         input logic [25:0] idx, input logic [31:0] pc,
                         input logic [31:0] rs);
    ex_valid       = 1'b1;
    ex_jump        = j;
    ex_jr          = jr;
    ex_link        = lnk;
    ex_instr_index = idx;
    ex_pc_plus4    = pc;
    ex_rs_value    = rs;
  endtask

  // Counts cycles until ex_accept returns, bounded.
  task automatic waitAccept(input string tag, input int expCycles);
    int n = 0;
    while (!ex_accept && n < 40) begin
      tick();
      n++;
    end
    chkWord(tag, 32'(n), 32'(expCycles));
  endtask

  initial begin
    reset_n     = 1'b0;
    redir_ready = 1'b0;
    idleInputs();
    repeat (2) @(posedge clock);
    #1;
    chkBit ("rst_redir_valid", redir_valid, 1'b0);
    chkBit ("rst_flush",       flush,       1'b0);
    chkBit ("rst_stall",       stall_ex,    1'b0);
    chkBit ("rst_link_we",     link_we,     1'b0);
    chkBit ("rst_misalign",    misalign_err, 1'b0);
    chkWord("rst_target",      redir_target, 32'h0);
    chkWord("rst_link_data",   link_data,   32'h0);
    chkWord("rst_link_reg",    32'(link_reg), 32'd31);
    chkBit ("rst_accept",      ex_accept,   1'b1);
    reset_n = 1'b1;
    tick();

    // J with ready high: one redirect cycle then two flush cycles.
    redir_ready = 1'b1;
    present(1'b1, 1'b0, 1'b0, 26'h0000100, 32'h40000010, 32'h0);
    expTarget.push_back(32'h40000400);
    tick();
    idleInputs();
    chkBit ("j_valid",   redir_valid, 1'b1);
    chkWord("j_target",  redir_target, popTarget());
    chkBit ("j_stall",   stall_ex, 1'b1);
    chkBit ("j_flush1",  flush, 1'b1);
    chkBit ("j_accept1", ex_accept, 1'b0);
    chkBit ("j_link_we", link_we, 1'b0);
    tick();
    chkBit ("j_valid_done", redir_valid, 1'b0);
    chkBit ("j_flush2",     flush, 1'b1);
    chkBit ("j_stall_done", stall_ex, 1'b0);
    chkBit ("j_accept2",    ex_accept, 1'b0);
    tick();
    chkBit ("j_flush3",  flush, 1'b1);
    chkBit ("j_accept3", ex_accept, 1'b0);
    tick();
    chkBit ("j_flush_end", flush, 1'b0);
    chkBit ("j_accept4",   ex_accept, 1'b1);

    // JAL: link write one cycle after capture.
    present(1'b1, 1'b0, 1'b1, 26'h0100040, 32'h00400008, 32'h0);
    expTarget.push_back(32'h00400100);
    expLink.push_back(32'h00400008);
    tick();
    idleInputs();
    chkBit ("jal_link_we",   link_we, 1'b1);
    chkWord("jal_link_reg",  32'(link_reg), 32'd31);
    chkWord("jal_link_data", link_data, popLink());
    chkWord("jal_target",    redir_target, popTarget());
    tick();
    chkBit ("jal_link_we_off", link_we, 1'b0);
    waitAccept("jal_back_idle", 2);

    // JR with fetch back-pressure for five cycles.
    redir_ready = 1'b0;
    present(1'b0, 1'b1, 1'b0, 26'h0, 32'h12345678, 32'h00400020);
    expTarget.push_back(32'h00400020);
    tick();
    idleInputs();
    heldTarget = popTarget();
    for (int i = 0; i < 5; i++) begin
      chkBit ($sformatf("jr_hold_valid%0d", i), redir_valid, 1'b1);
      chkWord($sformatf("jr_hold_target%0d", i), redir_target, heldTarget);
      chkBit ($sformatf("jr_hold_stall%0d", i), stall_ex, 1'b1);
      tick();
    end
    chkBit("jr_still_pending", redir_valid, 1'b1);
    redir_ready = 1'b1;
    tick();
    chkBit("jr_handshake_valid", redir_valid, 1'b0);
    chkBit("jr_handshake_flush", flush, 1'b1);
    waitAccept("jr_back_idle", 2);

    // JALR with a misaligned register target.
    present(1'b0, 1'b1, 1'b1, 26'h0, 32'h00400010, 32'h00400022);
    tick();
    idleInputs();
    chkBit("mis_err",     misalign_err, 1'b1);
    chkBit("mis_valid",   redir_valid, 1'b0);
    chkBit("mis_link_we", link_we, 1'b0);
    chkBit("mis_flush",   flush, 1'b0);
    chkBit("mis_accept",  ex_accept, 1'b0);
    tick();
    chkBit("mis_err_off", misalign_err, 1'b0);
    chkBit("mis_idle",    ex_accept, 1'b1);

    // Both jump kinds set: register target wins; jump during FLUSH ignored.
    present(1'b1, 1'b1, 1'b0, 26'h3FFFFFF, 32'hF0000004, 32'h00400080);
    expTarget.push_back(32'h00400080);
    tick();
    idleInputs();
    chkWord("both_target", redir_target, popTarget());
    chkBit ("both_valid",  redir_valid, 1'b1);
    tick();
    present(1'b1, 1'b0, 1'b0, 26'h0000001, 32'h00000000, 32'h0);
    chkBit("ign_accept1", ex_accept, 1'b0);
    chkBit("ign_flush",   flush, 1'b1);
    tick();
    chkBit("ign_accept2", ex_accept, 1'b0);
    chkBit("ign_valid2",  redir_valid, 1'b0);
    tick();
    idleInputs();
    chkBit ("ign_accept3", ex_accept, 1'b1);
    chkBit ("ign_valid3",  redir_valid, 1'b0);
    chkBit ("ign_flush3",  flush, 1'b0);
    chkWord("ign_target",  redir_target, 32'h00400080);

    // Reset during REDIRECT drops everything; next J captures normally.
    redir_ready = 1'b0;
    present(1'b1, 1'b0, 1'b1, 26'h0000200, 32'h00400004, 32'h0);
    tick();
    idleInputs();
    chkBit("prerst_valid", redir_valid, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chkBit ("mrst_valid",    redir_valid, 1'b0);
    chkBit ("mrst_flush",    flush, 1'b0);
    chkBit ("mrst_stall",    stall_ex, 1'b0);
    chkBit ("mrst_link_we",  link_we, 1'b0);
    chkWord("mrst_target",   redir_target, 32'h0);
    chkWord("mrst_link",     link_data, 32'h0);
    chkBit ("mrst_accept",   ex_accept, 1'b1);
    @(posedge clock);
    #1;
    reset_n     = 1'b1;
    redir_ready = 1'b1;
    present(1'b1, 1'b0, 1'b0, 26'h3FFFFFF, 32'h7FFFFFFC, 32'h0);
    expTarget.push_back(32'h7FFFFFFC);
    tick();
    idleInputs();
    chkBit ("post_valid",   redir_valid, 1'b1);
    chkWord("post_target",  redir_target, popTarget());
    chkBit ("post_link_we", link_we, 1'b0);
    waitAccept("post_back_idle", 3);

    chkWord("sb_target_empty", 32'(expTarget.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
